// File: rtl/vga_canvas_pkg.sv
// Shared definitions for the VGA drawing canvas.
//   - Pixel colours packed as {red, green, blue}, 4 bits each.
//   - Canvas controller state enum.
package vga_canvas_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam logic [11:0] C_BLANK     = 12'h222;
    localparam logic [11:0] C_CUR_IDLE  = 12'hF00;
    localparam logic [11:0] C_CUR_PEN   = 12'h00F;
    localparam logic [11:0] C_CUR_ERASE = 12'h0F0;
    localparam logic [11:0] C_INK       = 12'hF0F;
    localparam logic [11:0] C_PAPER     = 12'hFFF;
    localparam logic [11:0] C_BORDER    = 12'h33F;

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing from a single pixel clock.
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   h_cnt, v_cnt   : raw horizontal / vertical counters (sync pulse starts at 0)
//   active         : raster is inside the visible area
//   h_pos, v_pos   : position relative to the first visible pixel/line
//   hs_raw, vs_raw : high while inside the sync pulse (polarity applied by the user)
module vga_timing_gen #(
    parameter int unsigned H_SYNC = 128,
    parameter int unsigned H_BP   = 88,
    parameter int unsigned H_ACT  = 800,
    parameter int unsigned H_FP   = 40,
    parameter int unsigned V_SYNC = 4,
    parameter int unsigned V_BP   = 23,
    parameter int unsigned V_ACT  = 600,
    parameter int unsigned V_FP   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic        active,
    output logic [11:0] h_pos,
    output logic [11:0] v_pos,
    output logic        hs_raw,
    output logic        vs_raw
);

    localparam logic [11:0] H_LAST = 12'(H_SYNC + H_BP + H_ACT + H_FP - 1);
    localparam logic [11:0] V_LAST = 12'(V_SYNC + V_BP + V_ACT + V_FP - 1);
    localparam logic [11:0] H_OFF  = 12'(H_SYNC + H_BP);
    localparam logic [11:0] V_OFF  = 12'(V_SYNC + V_BP);
    localparam logic [11:0] H_END  = 12'(H_SYNC + H_BP + H_ACT);
    localparam logic [11:0] V_END  = 12'(V_SYNC + V_BP + V_ACT);
    localparam logic [11:0] H_SW   = 12'(H_SYNC);
    localparam logic [11:0] V_SW   = 12'(V_SYNC);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt  = h_cnt_q;
    assign v_cnt  = v_cnt_q;
    // End bounds are exclusive: the last visible pixel is H_END-1.
    assign active = (h_cnt_q >= H_OFF) && (h_cnt_q < H_END) &&
                    (v_cnt_q >= V_OFF) && (v_cnt_q < V_END);
    assign h_pos  = h_cnt_q - H_OFF;
    assign v_pos  = v_cnt_q - V_OFF;
    assign hs_raw = (h_cnt_q < H_SW);
    assign vs_raw = (v_cnt_q < V_SW);

endmodule

// File: rtl/vga_canvas_ctrl.sv
// VGA drawing front-end: raster timing, GRIDxGRID 1-bit canvas, cursor
// overlay, border rendering and a cell-by-cell canvas clear.
//   clkVga, iRstN         : pixel clock, asynchronous active-low reset
//   iCurX, iCurY          : cursor position in visible-area pixels
//   iPen, iErase          : set / clear the cell under the cursor (erase wins)
//   iClear                : pulse to wipe the canvas, one cell per clock
//   oRed, oGreen, oBlue   : registered pixel colour
//   oHs, oVs              : registered syncs, aligned with the colour
//   oBusy                 : high while the wipe is in progress
//   oImage                : canvas, bit index = col*GRID + row
module vga_canvas_ctrl
    import vga_canvas_pkg::*;
#(
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BP      = 88,
    parameter int unsigned H_ACT     = 800,
    parameter int unsigned H_FP      = 40,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BP      = 23,
    parameter int unsigned V_ACT     = 600,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned GRID_LOG2 = 5,
    parameter int unsigned CELL_LOG2 = 4,
    parameter int unsigned CUR_SIZE  = 16,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic                              clkVga,
    input  logic                              iRstN,
    input  logic [10:0]                       iCurX,
    input  logic [10:0]                       iCurY,
    input  logic                              iPen,
    input  logic                              iErase,
    input  logic                              iClear,
    output logic [3:0]                        oRed,
    output logic [3:0]                        oGreen,
    output logic [3:0]                        oBlue,
    output logic                              oHs,
    output logic                              oVs,
    output logic                              oBusy,
    output logic [(1 << (2*GRID_LOG2))-1:0]   oImage
);

    localparam int unsigned     IDX_W     = 2 * GRID_LOG2;
    localparam int unsigned     N_CELLS   = 1 << IDX_W;
    localparam logic [11:0]     CANVAS_PX = 12'(1 << (GRID_LOG2 + CELL_LOG2));
    localparam logic [11:0]     CUR_M1    = 12'(CUR_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [11:0] h_cnt, v_cnt, h_pos, v_pos;
    logic        active, hs_raw, vs_raw;

    vga_timing_gen #(
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .H_ACT  (H_ACT),
        .H_FP   (H_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP),
        .V_ACT  (V_ACT),
        .V_FP   (V_FP)
    ) u_timing (
        .clk    (clkVga),
        .rst_n  (iRstN),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .h_pos  (h_pos),
        .v_pos  (v_pos),
        .hs_raw (hs_raw),
        .vs_raw (vs_raw)
    );

    // Raw counters are available for debug; the pixel path works from positions.
    logic unused_cnt;
    assign unused_cnt = ^{h_cnt, v_cnt};

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     clr_idx_q, clr_idx_d;
    logic [N_CELLS-1:0]   image_q, image_d;
    logic [11:0]          rgb_q, rgb_d;
    logic                 hs_q, hs_d, vs_q, vs_d;

    // Write path: the cell under the cursor, only when the cursor is on the canvas.
    logic                 cur_in_canvas;
    logic [IDX_W-1:0]     wr_idx;

    assign cur_in_canvas = ({1'b0, iCurX} < CANVAS_PX) && ({1'b0, iCurY} < CANVAS_PX);
    assign wr_idx        = {iCurX[CELL_LOG2 +: GRID_LOG2], iCurY[CELL_LOG2 +: GRID_LOG2]};

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        image_d   = image_q;
        case (state_q)
            RUN: begin
                if (cur_in_canvas) begin
                    if (iErase)    image_d[wr_idx] = 1'b0;
                    else if (iPen) image_d[wr_idx] = 1'b1;
                end
                if (iClear) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            CLEAR: begin
                image_d[clr_idx_q] = 1'b0;
                clr_idx_d          = clr_idx_q + IDX_ONE;
                if (&clr_idx_q) begin
                    state_d   = RUN;
                    clr_idx_d = '0;
                end
            end
        endcase
    end

    // Pixel path. Cursor bounds are 12 bits wide so iCurX+CUR_SIZE never wraps.
    logic [11:0]      cur_x_lo, cur_x_hi, cur_y_lo, cur_y_hi;
    logic             on_cursor, in_canvas_px;
    logic [IDX_W-1:0] rd_idx;

    always_comb begin
        cur_x_lo     = {1'b0, iCurX};
        cur_y_lo     = {1'b0, iCurY};
        cur_x_hi     = cur_x_lo + CUR_M1;
        cur_y_hi     = cur_y_lo + CUR_M1;
        on_cursor    = (h_pos >= cur_x_lo) && (h_pos <= cur_x_hi) &&
                       (v_pos >= cur_y_lo) && (v_pos <= cur_y_hi);
        in_canvas_px = (h_pos < CANVAS_PX) && (v_pos < CANVAS_PX);
        rd_idx       = {h_pos[CELL_LOG2 +: GRID_LOG2], v_pos[CELL_LOG2 +: GRID_LOG2]};

        rgb_d = C_BORDER;
        if (!active)            rgb_d = C_BLANK;
        else if (on_cursor)     rgb_d = iErase ? C_CUR_ERASE : (iPen ? C_CUR_PEN : C_CUR_IDLE);
        else if (in_canvas_px)  rgb_d = image_q[rd_idx] ? C_INK : C_PAPER;

        hs_d = hs_raw ? SYNC_POL : ~SYNC_POL;
        vs_d = vs_raw ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= RUN;
            clr_idx_q <= '0;
            image_q   <= '0;
            rgb_q     <= '0;
            hs_q      <= SYNC_POL;
            vs_q      <= SYNC_POL;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            image_q   <= image_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    assign oRed   = rgb_q[11:8];
    assign oGreen = rgb_q[7:4];
    assign oBlue  = rgb_q[3:0];
    assign oHs    = hs_q;
    assign oVs    = vs_q;
    assign oBusy  = (state_q == CLEAR);
    assign oImage = image_q;

endmodule
